// File: rtl/alu_iq_pkg.sv
// Shared types for the ALU issue queue: opcode enum, operand/entry structs, XLEN.
// Latency: none (types and a pure combinational helper only).
// Backpressure: none.
package alu_iq_pkg;

  localparam int XLEN = 32;

  // Tags are stored at this width and zero-extended from the queue's TAG_W,
  // so TAG_W must not exceed it.
  localparam int TAG_MAX_W = 16;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3
  } alu_op_e;

  typedef struct packed {
    logic                 rdy;
    logic [TAG_MAX_W-1:0] tag;
    logic [XLEN-1:0]      val;
  } iq_src_t;

  typedef struct packed {
    logic                 valid;
    alu_op_e              op;
    iq_src_t              src1;
    iq_src_t              src2;
    logic [TAG_MAX_W-1:0] dst_tag;
  } iq_entry_t;

  // Capture a CDB broadcast into a source operand when it matched.
  function automatic iq_src_t wake_src(input iq_src_t s, input logic hit,
                                       input logic [XLEN-1:0] data);
    iq_src_t r;
    r = s;
    if (hit) begin
      r.rdy = 1'b1;
      r.val = data;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_iq_select.sv
// Oldest-ready picker: one-hot select of the lowest-index entry with both sources ready.
// Latency: purely combinational.
// Backpressure: none; any_ready simply stays low when nothing is eligible.
// Ports: valid/rdy1/rdy2 per-entry state, hit1/hit2 per-entry CDB tag matches,
//        sel one-hot pick, any_ready set when sel is non-zero.
// Build option ALU_IQ_WAKEUP_BYPASS_EN: a source matching the current CDB counts as ready.
module alu_iq_select #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0] valid,
  input  logic [DEPTH-1:0] rdy1,
  input  logic [DEPTH-1:0] rdy2,
  input  logic [DEPTH-1:0] hit1,
  input  logic [DEPTH-1:0] hit2,
  output logic [DEPTH-1:0] sel,
  output logic             any_ready
);

  logic [DEPTH-1:0] eligible;

`ifdef ALU_IQ_WAKEUP_BYPASS_EN
  assign eligible = valid & (rdy1 | hit1) & (rdy2 | hit2);
`else
  assign eligible = valid & rdy1 & rdy2;
  // Matches only feed the registered wakeup path in this build.
  logic unused_hits;
  assign unused_hits = ^{hit1, hit2};
`endif

  always_comb begin
    sel       = '0;
    any_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (eligible[i] && !any_ready) begin
        sel[i]    = 1'b1;
        any_ready = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Collapsing age-ordered ALU issue queue with CDB operand capture and registered issue.
// Latency: ready dispatch at edge E issues (grant) after edge E+1; CDB wakeup adds one
//          cycle unless ALU_IQ_WAKEUP_BYPASS_EN is defined.
// Backpressure: disp_ready = registered count < DEPTH; a full queue stalls dispatch
//          even when an issue frees a slot in the same cycle.
// Ports: dispatch (disp_*), CDB broadcast (cdb_*), flush squash, issue outputs
//        grant/a/b/alu_op/iss_dst_tag (all registered).
module alu_issue_queue
  import alu_iq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [3:0]       disp_alu_op,
  input  logic             disp_src1_rdy,
  input  logic             disp_src2_rdy,
  input  logic [XLEN-1:0]  disp_src1_val,
  input  logic [XLEN-1:0]  disp_src2_val,
  input  logic [TAG_W-1:0] disp_src1_tag,
  input  logic [TAG_W-1:0] disp_src2_tag,
  input  logic [TAG_W-1:0] disp_dst_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
  output logic             grant,
  output logic [XLEN-1:0]  a,
  output logic [XLEN-1:0]  b,
  output logic [3:0]       alu_op,
  output logic [TAG_W-1:0] iss_dst_tag
);

  localparam int CW = $clog2(DEPTH + 1);

  iq_entry_t            q  [DEPTH];  // registered entries, index 0 oldest
  iq_entry_t            wq [DEPTH];  // entries after this cycle's wakeup
  iq_entry_t            nq [DEPTH];  // next state before flush
  iq_entry_t            din;
  logic [CW-1:0]        count, count_nxt, wr_idx;
  logic [DEPTH-1:0]     vld, rdy1, rdy2, hit1, hit2, sel;
  logic                 any, accept, passed;
  logic [TAG_MAX_W-1:0] cdb_tag_x;
  logic [XLEN-1:0]      iss_a, iss_b;
  logic [3:0]           iss_op;
  logic [TAG_W-1:0]     iss_dst;

  assign cdb_tag_x  = TAG_MAX_W'(cdb_tag);
  assign disp_ready = (count < CW'(DEPTH));
  assign accept     = disp_valid && disp_ready && !flush;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      vld[i]     = q[i].valid;
      rdy1[i]    = q[i].src1.rdy;
      rdy2[i]    = q[i].src2.rdy;
      hit1[i]    = q[i].valid && cdb_valid && !q[i].src1.rdy && (q[i].src1.tag == cdb_tag_x);
      hit2[i]    = q[i].valid && cdb_valid && !q[i].src2.rdy && (q[i].src2.tag == cdb_tag_x);
      wq[i]      = q[i];
      wq[i].src1 = wake_src(q[i].src1, hit1[i], cdb_data);
      wq[i].src2 = wake_src(q[i].src2, hit2[i], cdb_data);
    end
  end

  // Incoming entry, including capture of a broadcast landing in its dispatch cycle.
  always_comb begin
    din          = '0;
    din.valid    = 1'b1;
    din.op       = alu_op_e'(disp_alu_op);
    din.src1.rdy = disp_src1_rdy;
    din.src1.tag = TAG_MAX_W'(disp_src1_tag);
    din.src1.val = disp_src1_val;
    din.src2.rdy = disp_src2_rdy;
    din.src2.tag = TAG_MAX_W'(disp_src2_tag);
    din.src2.val = disp_src2_val;
    din.dst_tag  = TAG_MAX_W'(disp_dst_tag);
    din.src1     = wake_src(din.src1,
                            cdb_valid && !disp_src1_rdy && (din.src1.tag == cdb_tag_x), cdb_data);
    din.src2     = wake_src(din.src2,
                            cdb_valid && !disp_src2_rdy && (din.src2.tag == cdb_tag_x), cdb_data);
  end

  alu_iq_select #(.DEPTH(DEPTH)) u_select (
    .valid     (vld),
    .rdy1      (rdy1),
    .rdy2      (rdy2),
    .hit1      (hit1),
    .hit2      (hit2),
    .sel       (sel),
    .any_ready (any)
  );

  always_comb begin
    // Operand values come from the woken copy, so a bypassed source reads cdb_data.
    iss_a   = '0;
    iss_b   = '0;
    iss_op  = '0;
    iss_dst = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        iss_a   = wq[i].src1.val;
        iss_b   = wq[i].src2.val;
        iss_op  = wq[i].op;
        iss_dst = wq[i].dst_tag[TAG_W-1:0];
      end
    end

    // Collapse: every entry at or above the selected index takes its upper neighbour.
    passed = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      passed = passed | sel[i];
      nq[i]  = passed ? wq[i+1] : wq[i];
    end
    nq[DEPTH-1] = (passed || sel[DEPTH-1]) ? '0 : wq[DEPTH-1];

    // Append at the tail, which moves down one slot when an issue leaves this cycle.
    wr_idx = any ? (count - CW'(1)) : count;
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && (wr_idx == CW'(i))) nq[i] = din;
    end

    count_nxt = count + CW'(accept) - CW'(any);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      grant       <= 1'b0;
      a           <= '0;
      b           <= '0;
      alu_op      <= '0;
      iss_dst_tag <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (flush) begin
      count <= '0;
      grant <= 1'b0;
      for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
    end else begin
      count <= count_nxt;
      grant <= any;
      for (int i = 0; i < DEPTH; i++) q[i] <= nq[i];
      if (any) begin
        a           <= iss_a;
        b           <= iss_b;
        alu_op      <= iss_op;
        iss_dst_tag <= iss_dst;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: directed scenarios plus randomized traffic against a
// queue-based reference model. Works in both the default and bypass builds.
module tb_alu_issue_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
`ifdef ALU_IQ_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, flush, disp_valid, disp_ready;
  logic [3:0] disp_alu_op;
  logic disp_src1_rdy, disp_src2_rdy;
  logic [31:0] disp_src1_val, disp_src2_val;
  logic [TAG_W-1:0] disp_src1_tag, disp_src2_tag, disp_dst_tag;
  logic cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0] cdb_data;
  logic grant;
  logic [31:0] a, b;
  logic [3:0] alu_op;
  logic [TAG_W-1:0] iss_dst_tag;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_alu_op(disp_alu_op),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_dst_tag(disp_dst_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .grant(grant), .a(a), .b(b), .alu_op(alu_op),
    .iss_dst_tag(iss_dst_tag)
  );

  // ---------------- reference model: an ordered list of waiting ops ----------------
  typedef struct {
    logic [3:0]  op;
    bit          r1, r2;
    logic [3:0]  t1, t2;
    logic [31:0] v1, v2;
    logic [3:0]  dst;
  } m_ent_t;

  m_ent_t      mq[$];
  logic        m_grant;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_op, m_dst;

  function automatic bit hits(bit r, logic [3:0] t);
    return !r && cdb_valid && (t == cdb_tag);
  endfunction

  function automatic bit src_ok(bit r, logic [3:0] t);
    return r || (BYP && hits(r, t));
  endfunction

  task automatic m_reset();
    mq.delete();
    m_grant = 1'b0; m_a = '0; m_b = '0; m_op = '0; m_dst = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int pick;
    bit acc;
    m_ent_t e;
    if (flush) begin
      mq.delete();
      m_grant = 1'b0;
      return;
    end
    acc  = disp_valid && (mq.size() < DEPTH);
    pick = -1;
    for (int i = 0; i < mq.size(); i++)
      if (pick < 0 && src_ok(mq[i].r1, mq[i].t1) && src_ok(mq[i].r2, mq[i].t2)) pick = i;
    if (pick >= 0) begin
      m_grant = 1'b1;
      m_a     = mq[pick].r1 ? mq[pick].v1 : cdb_data;
      m_b     = mq[pick].r2 ? mq[pick].v2 : cdb_data;
      m_op    = mq[pick].op;
      m_dst   = mq[pick].dst;
      mq.delete(pick);
    end else begin
      m_grant = 1'b0;
    end
    for (int i = 0; i < mq.size(); i++) begin
      e = mq[i];
      if (hits(e.r1, e.t1)) begin e.r1 = 1'b1; e.v1 = cdb_data; end
      if (hits(e.r2, e.t2)) begin e.r2 = 1'b1; e.v2 = cdb_data; end
      mq[i] = e;
    end
    if (acc) begin
      e.op = disp_alu_op; e.dst = disp_dst_tag;
      e.r1 = disp_src1_rdy; e.t1 = disp_src1_tag; e.v1 = disp_src1_val;
      e.r2 = disp_src2_rdy; e.t2 = disp_src2_tag; e.v2 = disp_src2_val;
      if (hits(e.r1, e.t1)) begin e.r1 = 1'b1; e.v1 = cdb_data; end
      if (hits(e.r2, e.t2)) begin e.r2 = 1'b1; e.v2 = cdb_data; end
      mq.push_back(e);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; disp_valid = 1'b0; disp_alu_op = '0;
    disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0;
    disp_src1_val = '0; disp_src2_val = '0;
    disp_src1_tag = '0; disp_src2_tag = '0; disp_dst_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic set_disp(input logic [3:0] op, input bit r1, input logic [3:0] t1,
                          input logic [31:0] v1, input bit r2, input logic [3:0] t2,
                          input logic [31:0] v2, input logic [3:0] dst);
    disp_valid = 1'b1; disp_alu_op = op;
    disp_src1_rdy = r1; disp_src1_tag = t1; disp_src1_val = v1;
    disp_src2_rdy = r2; disp_src2_tag = t2; disp_src2_val = v2;
    disp_dst_tag = dst;
  endtask

  task automatic set_cdb(input logic [3:0] t, input logic [31:0] d);
    cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
  endtask

  task automatic clear();
    idle(); flush = 1'b1; tick(); flush = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle(); rst_n = 1'b0; m_reset();
    @(posedge clk); @(posedge clk); #1;
    n_cmp++; if (grant !== 1'b0) begin n_fail++; $display("FAIL reset_grant: got %b want 0", grant); end
    n_cmp++; if (a !== 32'h0) begin n_fail++; $display("FAIL reset_a: got %h want 0", a); end
    n_cmp++; if (b !== 32'h0) begin n_fail++; $display("FAIL reset_b: got %h want 0", b); end
    n_cmp++; if (alu_op !== 4'h0) begin n_fail++; $display("FAIL reset_op: got %h want 0", alu_op); end
    n_cmp++; if (iss_dst_tag !== 4'h0) begin n_fail++; $display("FAIL reset_dst: got %h want 0", iss_dst_tag); end
    n_cmp++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", disp_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    clear();
    set_disp(4'd0, 1, 4'd0, 32'd5, 1, 4'd0, 32'd7, 4'd1);
    tick(); idle();
    n_cmp++; if (grant !== 1'b0 || disp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_early: grant=%b ready=%b want 0/1", grant, disp_ready);
    end
    tick();
    n_cmp++; if (grant !== 1'b1 || a !== 32'd5 || b !== 32'd7 || alu_op !== 4'd0 ||
                 iss_dst_tag !== 4'd1 || disp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_issue: grant=%b a=%h b=%h op=%h dst=%h ready=%b want 1/5/7/0/1/1",
               grant, a, b, alu_op, iss_dst_tag, disp_ready);
    end
    tick();
    n_cmp++; if (grant !== 1'b0) begin n_fail++; $display("FAIL basic_once: grant=%b want 0", grant); end
  endtask

  task automatic test_wakeup();
    clear();
    set_disp(4'd1, 0, 4'd3, 32'h0, 1, 4'd0, 32'h4, 4'd7);
    tick(); idle();
    tick();
    set_cdb(4'd3, 32'h10);
    tick(); idle();
    n_cmp++; if (grant !== BYP) begin n_fail++; $display("FAIL wake_timing: grant=%b want %b", grant, BYP); end
    if (!BYP) tick();
    n_cmp++; if (grant !== 1'b1 || a !== 32'h10 || b !== 32'h4 || alu_op !== 4'd1 || iss_dst_tag !== 4'd7) begin
      n_fail++;
      $display("FAIL wake_issue: grant=%b a=%h b=%h op=%h dst=%h want 1/10/4/1/7",
               grant, a, b, alu_op, iss_dst_tag);
    end
  endtask

  task automatic test_multi_wake();
    logic [3:0] tags [4];
    tags[0] = 4'd5; tags[1] = 4'd6; tags[2] = 4'd5; tags[3] = 4'd7;
    clear();
    for (int i = 0; i < 4; i++) begin
      set_disp(4'd2, 0, tags[i], 32'h0, 1, 4'd0, 32'h1, 4'(i));
      tick();
    end
    idle();
    n_cmp++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL mw_full: ready=%b want 0", disp_ready); end
    set_cdb(4'd5, 32'h55);
    tick(); idle();
    n_cmp++; if (grant !== BYP) begin n_fail++; $display("FAIL mw_timing: grant=%b want %b", grant, BYP); end
    if (!BYP) tick();
    n_cmp++; if (grant !== 1'b1 || iss_dst_tag !== 4'd0 || a !== 32'h55 || disp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mw_first: grant=%b dst=%h a=%h ready=%b want 1/0/55/1",
               grant, iss_dst_tag, a, disp_ready);
    end
    tick();
    n_cmp++; if (grant !== 1'b1 || iss_dst_tag !== 4'd2 || a !== 32'h55) begin
      n_fail++;
      $display("FAIL mw_second: grant=%b dst=%h a=%h want 1/2/55", grant, iss_dst_tag, a);
    end
  endtask

  task automatic test_full();
    clear();
    set_disp(4'd0, 0, 4'd9, 32'h0, 1, 4'd0, 32'h2, 4'd10); tick();
    for (int i = 1; i < 4; i++) begin
      set_disp(4'd0, 0, 4'd8, 32'h0, 1, 4'd0, 32'h2, 4'(10 + i));
      tick();
    end
    set_disp(4'd3, 1, 4'd0, 32'h3, 1, 4'd0, 32'h4, 4'd14);
    set_cdb(4'd9, 32'h99);
    tick();
    cdb_valid = 1'b0;
    n_cmp++; if (grant !== BYP || disp_ready !== BYP) begin
      n_fail++;
      $display("FAIL full_timing: grant=%b ready=%b want %b/%b", grant, disp_ready, BYP, BYP);
    end
    if (!BYP) tick();
    n_cmp++; if (grant !== 1'b1 || iss_dst_tag !== 4'd10 || a !== 32'h99 || disp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_issue: grant=%b dst=%h a=%h ready=%b want 1/a/99/1",
               grant, iss_dst_tag, a, disp_ready);
    end
    tick();
    idle();
    n_cmp++; if (disp_ready !== 1'b0 || grant !== 1'b0) begin
      n_fail++;
      $display("FAIL full_accept: ready=%b grant=%b want 0/0", disp_ready, grant);
    end
    tick();
    n_cmp++; if (grant !== 1'b1 || iss_dst_tag !== 4'd14 || alu_op !== 4'd3) begin
      n_fail++;
      $display("FAIL full_tail: grant=%b dst=%h op=%h want 1/e/3", grant, iss_dst_tag, alu_op);
    end
    set_cdb(4'd8, 32'h88);
    tick(); idle();
    n_cmp++; if (grant !== BYP) begin n_fail++; $display("FAIL full_wake: grant=%b want %b", grant, BYP); end
    if (!BYP) tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (grant !== 1'b1 || iss_dst_tag !== 4'(11 + k) || a !== 32'h88) begin
        n_fail++;
        $display("FAIL full_order%0d: grant=%b dst=%h a=%h want 1/%h/88",
                 k, grant, iss_dst_tag, a, 4'(11 + k));
      end
      tick();
    end
  endtask

  task automatic test_flush();
    clear();
    set_disp(4'd0, 0, 4'd4, 32'h0, 1, 4'd0, 32'h0, 4'd1); tick();
    set_disp(4'd0, 0, 4'd4, 32'h0, 1, 4'd0, 32'h0, 4'd2); tick();
    set_disp(4'd1, 1, 4'd0, 32'h1, 1, 4'd0, 32'h2, 4'd3); tick();
    idle(); flush = 1'b1;
    tick(); flush = 1'b0;
    n_cmp++; if (grant !== 1'b0 || disp_ready !== 1'b1 || dut.count !== 3'd0) begin
      n_fail++;
      $display("FAIL flush_state: grant=%b ready=%b count=%0d want 0/1/0",
               grant, disp_ready, dut.count);
    end
    set_cdb(4'd4, 32'h44);
    tick(); idle();
    n_cmp++; if (grant !== 1'b0) begin n_fail++; $display("FAIL flush_stale1: grant=%b want 0", grant); end
    tick();
    n_cmp++; if (grant !== 1'b0) begin n_fail++; $display("FAIL flush_stale2: grant=%b want 0", grant); end
  endtask

  task automatic test_disp_capture();
    clear();
    set_disp(4'd2, 0, 4'd6, 32'hdead, 0, 4'd6, 32'hbeef, 4'd5);
    set_cdb(4'd6, 32'habcd);
    tick(); idle();
    n_cmp++; if (grant !== 1'b0) begin n_fail++; $display("FAIL cap_early: grant=%b want 0", grant); end
    tick();
    n_cmp++; if (grant !== 1'b1 || a !== 32'habcd || b !== 32'habcd || alu_op !== 4'd2 || iss_dst_tag !== 4'd5) begin
      n_fail++;
      $display("FAIL cap_issue: grant=%b a=%h b=%h op=%h dst=%h want 1/abcd/abcd/2/5",
               grant, a, b, alu_op, iss_dst_tag);
    end
  endtask

  task automatic test_reset_mid();
    clear();
    set_disp(4'd3, 1, 4'd0, 32'hf0, 1, 4'd0, 32'h0f, 4'd9); tick(); idle();
    tick();
    n_cmp++; if (grant !== 1'b1 || a !== 32'hf0) begin
      n_fail++;
      $display("FAIL rmid_pre: grant=%b a=%h want 1/f0", grant, a);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (grant !== 1'b0 || a !== 32'h0 || b !== 32'h0 || alu_op !== 4'h0 ||
                 iss_dst_tag !== 4'h0 || disp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_async: grant=%b a=%h b=%h op=%h dst=%h ready=%b want 0/0/0/0/0/1",
               grant, a, b, alu_op, iss_dst_tag, disp_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_random();
    bit exp_rdy;
    clear();
    for (int c = 0; c < 600; c++) begin
      disp_valid    = ($urandom_range(0, 9) < 6);
      disp_alu_op   = 4'($urandom_range(0, 3));
      disp_src1_rdy = $urandom_range(0, 1) == 1;
      disp_src2_rdy = $urandom_range(0, 1) == 1;
      disp_src1_tag = 4'($urandom_range(0, 5));
      disp_src2_tag = 4'($urandom_range(0, 5));
      disp_src1_val = $urandom;
      disp_src2_val = $urandom;
      disp_dst_tag  = 4'($urandom_range(0, 15));
      cdb_valid     = $urandom_range(0, 1) == 1;
      cdb_tag       = 4'($urandom_range(0, 5));
      cdb_data      = $urandom;
      flush         = ($urandom_range(0, 31) == 0);
      tick();
      exp_rdy = (mq.size() < DEPTH);
      n_cmp++; if (grant !== m_grant || disp_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rnd_ctrl cyc %0d: grant=%b ready=%b want %b/%b",
                 c, grant, disp_ready, m_grant, exp_rdy);
      end
      n_cmp++; if (a !== m_a || b !== m_b || alu_op !== m_op || iss_dst_tag !== m_dst) begin
        n_fail++;
        $display("FAIL rnd_data cyc %0d: a=%h b=%h op=%h dst=%h want %h/%h/%h/%h",
                 c, a, b, alu_op, iss_dst_tag, m_a, m_b, m_op, m_dst);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_multi_wake();
    test_full();
    test_flush();
    test_disp_capture();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
